// File: rtl/fwrisc_trace_sched_pkg.sv
// fwrisc_trace_sched_pkg: shared encodings, config register map and the
// packed FIFO entry used by the fwrisc trace event scheduler.
package fwrisc_trace_sched_pkg;

    // Event kind carried on ev_kind.
    typedef enum logic [1:0] {
        EV_INSTR = 2'd0,
        EV_REG   = 2'd1,
        EV_MEM   = 2'd2,
        EV_RSVD  = 2'd3
    } ev_kind_e;

    // Config register indices.
    localparam logic [3:0] CFG_EN         = 4'd0;
    localparam logic [3:0] CFG_STATUS     = 4'd1;
    localparam logic [3:0] CFG_DROP_INSTR = 4'd2;
    localparam logic [3:0] CFG_DROP_REG   = 4'd3;
    localparam logic [3:0] CFG_DROP_MEM   = 4'd4;
    localparam logic [3:0] CFG_SEQ        = 4'd5;
    localparam logic [3:0] CFG_BP_BASE    = 4'd8;

    // One buffered trace event.
    typedef struct packed {
        logic [15:0] seq;
        logic        bp;
        logic [3:0]  strb;
        logic [31:0] data;
        logic [31:0] addr;
    } trace_entry_t;

    // True when stamp a was issued before stamp b. The signed difference is
    // exact because far fewer than 2^15 events are ever outstanding.
    function automatic logic seq_before(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] diff;
        diff = a - b;
        return diff[15];
    endfunction

endpackage

// File: rtl/fwrisc_trace_event_sched_if.sv
// fwrisc_trace_event_sched_if: the scheduler's output event stream.
// Handshake: an event transfers on a rising clock edge where ev_valid and
// ev_ready are both high. Once ev_valid is raised, the producer holds it and
// every ev_* payload signal stable until that transfer; ev_ready may change
// freely and does not depend on ev_valid.
interface fwrisc_trace_event_sched_if;
    logic        ev_valid;
    logic        ev_ready;
    logic [1:0]  ev_kind;
    logic [31:0] ev_addr;
    logic [31:0] ev_data;
    logic [3:0]  ev_strb;
    logic [15:0] ev_seq;
    logic        ev_bp;

    modport master (
        output ev_valid, ev_kind, ev_addr, ev_data, ev_strb, ev_seq, ev_bp,
        input  ev_ready
    );

    modport slave (
        input  ev_valid, ev_kind, ev_addr, ev_data, ev_strb, ev_seq, ev_bp,
        output ev_ready
    );
endinterface

// File: rtl/fwrisc_trace_fifo.sv
// fwrisc_trace_fifo: single-clock FIFO with a combinational head. The caller
// only pushes when not full, or when full and popping in the same cycle.
module fwrisc_trace_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];

    // Pointer update; the extra MSB distinguishes full from empty.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; contents need no reset since the pointers define validity.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/fwrisc_trace_event_sched.sv
// fwrisc_trace_event_sched: captures instruction-retire, register-write and
// memory-write trace taps into per-source FIFOs, stamps each accepted event
// with a shared sequence number and emits them one per handshake in program
// order. Optional build macro FWRISC_TRACE_SCHED_HWBP_EN adds N_HW_BP PC
// breakpoint comparators (config registers 8.., at most 8 addressable).
module fwrisc_trace_event_sched
    import fwrisc_trace_sched_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int N_HW_BP = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic [31:0] instr,
    input  logic        ivalid,
    input  logic [5:0]  rd_waddr,
    input  logic [31:0] rd_wdata,
    input  logic        rd_write,
    input  logic [31:0] maddr,
    input  logic [31:0] mdata,
    input  logic [3:0]  mstrb,
    input  logic        mwrite,
    input  logic        mvalid,
    input  logic        cfg_we,
    input  logic [3:0]  cfg_addr,
    input  logic [31:0] cfg_wdata,
    output logic [31:0] cfg_rdata,
    fwrisc_trace_event_sched_if.master ev
);
    localparam int N_SRC = 3;

    logic [2:0]       en;
    logic [2:0]       ovf;
    logic [15:0]      seq;
    logic [15:0]      seq_next;
    logic [15:0]      drop_cnt [N_SRC];
    logic [15:0]      stamp    [N_SRC];
    trace_entry_t     push_entry [N_SRC];
    trace_entry_t     head       [N_SRC];
    logic [N_SRC-1:0] push_req, fifo_push, fifo_drop, fifo_pop, fifo_full, fifo_empty;
    logic             bp_hit;
    logic [31:0]      bp_rdata;

    logic             load;
    logic             have_sel;
    logic [1:0]       sel;
    logic [15:0]      best_seq;

    logic             out_valid;
    logic [1:0]       out_kind;
    trace_entry_t     out_entry;

    logic             cfg_wr_en, cfg_wr_status;
    logic [N_SRC-1:0] cfg_wr_drop;

    assign cfg_wr_en      = cfg_we && (cfg_addr == CFG_EN);
    assign cfg_wr_status  = cfg_we && (cfg_addr == CFG_STATUS);
    assign cfg_wr_drop[0] = cfg_we && (cfg_addr == CFG_DROP_INSTR);
    assign cfg_wr_drop[1] = cfg_we && (cfg_addr == CFG_DROP_REG);
    assign cfg_wr_drop[2] = cfg_we && (cfg_addr == CFG_DROP_MEM);

`ifdef FWRISC_TRACE_SCHED_HWBP_EN
    logic [N_HW_BP-1:0] bp_valid;
    logic [30:0]        bp_addr [N_HW_BP];
    logic [N_HW_BP-1:0] bp_match;
    logic [N_HW_BP-1:0] bp_wr;

    // Breakpoint address compare and config decode per entry.
    always_comb begin
        bp_match = '0;
        bp_wr    = '0;
        bp_rdata = '0;
        for (int i = 0; i < N_HW_BP; i++) begin
            bp_match[i] = bp_valid[i] && (pc == {bp_addr[i], 1'b0});
            bp_wr[i]    = cfg_we && (cfg_addr == 4'(CFG_BP_BASE + i));
            if (cfg_addr == 4'(CFG_BP_BASE + i)) bp_rdata = {bp_addr[i], bp_valid[i]};
        end
    end

    assign bp_hit = |bp_match;

    // Breakpoint entry registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            bp_valid <= '0;
            for (int i = 0; i < N_HW_BP; i++) bp_addr[i] <= '0;
        end else begin
            for (int i = 0; i < N_HW_BP; i++) begin
                if (bp_wr[i]) begin
                    bp_valid[i] <= cfg_wdata[0];
                    bp_addr[i]  <= cfg_wdata[31:1];
                end
            end
        end
    end
`else
    logic unused_cfg;

    assign bp_hit     = 1'b0;
    assign bp_rdata   = '0;
    assign unused_cfg = ^{cfg_wdata[31:3], 32'(N_HW_BP)};
`endif

    // Push qualification; a breakpoint hit overrides a disabled instr source.
    always_comb begin
        push_req[0] = ivalid && (en[0] || bp_hit);
        push_req[1] = rd_write && (rd_waddr != 6'd0) && en[1];
        push_req[2] = mvalid && mwrite && en[2];
    end

    // A full FIFO can still accept when its head leaves in the same cycle.
    assign fifo_push = push_req & (~fifo_full | fifo_pop);
    assign fifo_drop = push_req & ~fifo_push;

    // Stamps are handed out in instr, reg, mem order; drops take none.
    always_comb begin
        stamp[0] = seq;
        stamp[1] = seq + 16'(fifo_push[0]);
        stamp[2] = stamp[1] + 16'(fifo_push[1]);
        seq_next = stamp[2] + 16'(fifo_push[2]);
    end

    // Build the entry written into each source FIFO.
    always_comb begin
        push_entry[0] = '{seq: stamp[0], bp: bp_hit, strb: 4'hF, data: instr, addr: pc};
        push_entry[1] = '{seq: stamp[1], bp: 1'b0, strb: 4'hF, data: rd_wdata,
                          addr: {26'd0, rd_waddr}};
        push_entry[2] = '{seq: stamp[2], bp: 1'b0, strb: mstrb, data: mdata, addr: maddr};
    end

    for (genvar g = 0; g < N_SRC; g++) begin : g_fifo
        fwrisc_trace_fifo #(
            .DEPTH (DEPTH),
            .W     ($bits(trace_entry_t))
        ) u_fifo (
            .clock (clock),
            .reset (reset),
            .push  (fifo_push[g]),
            .wdata (push_entry[g]),
            .pop   (fifo_pop[g]),
            .full  (fifo_full[g]),
            .empty (fifo_empty[g]),
            .head  (head[g])
        );
    end

    // Oldest non-empty head wins, judged by wrap-safe stamp comparison.
    always_comb begin
        have_sel = 1'b0;
        sel      = 2'd0;
        best_seq = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (!fifo_empty[i] && (!have_sel || seq_before(head[i].seq, best_seq))) begin
                have_sel = 1'b1;
                sel      = 2'(i);
                best_seq = head[i].seq;
            end
        end
    end

    assign load = !out_valid || ev.ev_ready;

    // Pop the selected head whenever the output stage takes it.
    always_comb begin
        fifo_pop = '0;
        if (load && have_sel) fifo_pop[sel] = 1'b1;
    end

    // Output stage: refills when empty or firing, holds under backpressure.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_kind  <= '0;
            out_entry <= '0;
        end else if (load) begin
            out_valid <= have_sel;
            if (have_sel) begin
                out_kind  <= sel;
                out_entry <= head[sel];
            end
        end
    end

    assign ev.ev_valid = out_valid;
    assign ev.ev_kind  = out_kind;
    assign ev.ev_addr  = out_entry.addr;
    assign ev.ev_data  = out_entry.data;
    assign ev.ev_strb  = out_entry.strb;
    assign ev.ev_seq   = out_entry.seq;
    assign ev.ev_bp    = out_entry.bp;

    // Sequence counter, enables, sticky overflow and saturating drop counters.
    // A drop in the same cycle as a clear is kept rather than lost.
    always_ff @(posedge clock) begin
        if (reset) begin
            seq <= '0;
            en  <= 3'b111;
            ovf <= '0;
            for (int i = 0; i < N_SRC; i++) drop_cnt[i] <= '0;
        end else begin
            seq <= seq_next;
            if (cfg_wr_en) en <= cfg_wdata[2:0];
            ovf <= (ovf & ~(cfg_wr_status ? cfg_wdata[2:0] : 3'b000)) | fifo_drop;
            for (int i = 0; i < N_SRC; i++) begin
                if (cfg_wr_drop[i])
                    drop_cnt[i] <= 16'(fifo_drop[i]);
                else if (fifo_drop[i] && (drop_cnt[i] != 16'hFFFF))
                    drop_cnt[i] <= drop_cnt[i] + 16'd1;
            end
        end
    end

    // Combinational config read; unmapped indices return zero.
    always_comb begin
        cfg_rdata = '0;
        case (cfg_addr)
            CFG_EN:         cfg_rdata = {29'd0, en};
            CFG_STATUS:     cfg_rdata = {26'd0, fifo_empty, ovf};
            CFG_DROP_INSTR: cfg_rdata = {16'd0, drop_cnt[0]};
            CFG_DROP_REG:   cfg_rdata = {16'd0, drop_cnt[1]};
            CFG_DROP_MEM:   cfg_rdata = {16'd0, drop_cnt[2]};
            CFG_SEQ:        cfg_rdata = {16'd0, seq};
            default:        cfg_rdata = bp_rdata;
        endcase
    end

endmodule

// File: tb/tb_fwrisc_trace_event_sched.sv
// tb_fwrisc_trace_event_sched: scoreboard bench for the trace event scheduler.
module tb_fwrisc_trace_event_sched;
    import fwrisc_trace_sched_pkg::*;

    localparam int DEPTH = 4;
    localparam int EW    = 87;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pc = '0, instr = '0, rd_wdata = '0, maddr = '0, mdata = '0;
    logic        ivalid = 1'b0, rd_write = 1'b0, mwrite = 1'b0, mvalid = 1'b0;
    logic [5:0]  rd_waddr = '0;
    logic [3:0]  mstrb = '0;
    logic        cfg_we = 1'b0;
    logic [3:0]  cfg_addr = '0;
    logic [31:0] cfg_wdata = '0;
    logic [31:0] cfg_rdata;

    fwrisc_trace_event_sched_if ev_if ();

    fwrisc_trace_event_sched #(.DEPTH(DEPTH), .N_HW_BP(8)) dut (
        .clock(clock), .reset(reset),
        .pc(pc), .instr(instr), .ivalid(ivalid),
        .rd_waddr(rd_waddr), .rd_wdata(rd_wdata), .rd_write(rd_write),
        .maddr(maddr), .mdata(mdata), .mstrb(mstrb), .mwrite(mwrite), .mvalid(mvalid),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata),
        .ev(ev_if)
    );

    // Clock / reset-state bookkeeping
    int          n_checks = 0;
    int          n_fails  = 0;
    int          cyc      = 0;
    bit          mon_en   = 1'b1;
    logic [15:0] m_seq    = '0;

    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] obs_q[$];
    int            obs_t[$];

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [EW-1:0] cur_ev();
        return {ev_if.ev_kind, ev_if.ev_addr, ev_if.ev_data, ev_if.ev_strb, ev_if.ev_seq, ev_if.ev_bp};
    endfunction

    // Monitor: record every event that transfers on the coming edge.
    always @(negedge clock) begin
        if (mon_en && !reset && ev_if.ev_valid && ev_if.ev_ready) begin
            obs_q.push_back(cur_ev());
            obs_t.push_back(cyc);
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, n_checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    // Driver tasks
    task automatic step();
        @(posedge clock);
        #1;
        ivalid   = 1'b0;
        rd_write = 1'b0;
        mvalid   = 1'b0;
        mwrite   = 1'b0;
        cfg_we   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic set_instr(input logic [31:0] a, input logic [31:0] d, input bit exp_ok, input bit bp);
        pc = a; instr = d; ivalid = 1'b1;
        if (exp_ok) begin
            exp_q.push_back({2'd0, a, d, 4'hF, m_seq, bp});
            m_seq = m_seq + 16'd1;
        end
    endtask

    task automatic set_reg(input logic [5:0] a, input logic [31:0] d, input bit exp_ok);
        rd_waddr = a; rd_wdata = d; rd_write = 1'b1;
        if (exp_ok) begin
            exp_q.push_back({2'd1, {26'd0, a}, d, 4'hF, m_seq, 1'b0});
            m_seq = m_seq + 16'd1;
        end
    endtask

    task automatic set_mem(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input bit exp_ok);
        maddr = a; mdata = d; mstrb = s; mvalid = 1'b1; mwrite = 1'b1;
        if (exp_ok) begin
            exp_q.push_back({2'd2, a, d, s, m_seq, 1'b0});
            m_seq = m_seq + 16'd1;
        end
    endtask

    task automatic cfg_write(input logic [3:0] a, input logic [31:0] d);
        cfg_addr = a; cfg_wdata = d; cfg_we = 1'b1;
        step();
    endtask

    task automatic cfg_read(input logic [3:0] a, output logic [31:0] d);
        cfg_addr = a;
        #1;
        d = cfg_rdata;
    endtask

    task automatic wait_obs(input int n, input int budget, output bit ok);
        int k;
        k = 0;
        while (obs_q.size() < n && k < budget) begin
            step();
            k++;
        end
        ok = (obs_q.size() >= n);
    endtask

    // Scenario tasks
    task automatic test_reset();
        logic [31:0] rd;
        reset = 1'b1;
        idle(3);
        reset = 1'b0;
        n_checks++;
        if ({ev_if.ev_valid, cur_ev()} !== '0) begin
            n_fails++;
            $display("FAIL reset_outputs: got valid=%b ev=%h, want all zero", ev_if.ev_valid, cur_ev());
        end
        cfg_read(CFG_EN, rd);
        n_checks++;
        if (rd !== 32'h7) begin n_fails++; $display("FAIL reset_en: got %h want %h", rd, 32'h7); end
        cfg_read(CFG_STATUS, rd);
        n_checks++;
        if (rd !== 32'h38) begin n_fails++; $display("FAIL reset_status: got %h want %h", rd, 32'h38); end
        cfg_read(CFG_SEQ, rd);
        n_checks++;
        if (rd !== 32'h0) begin n_fails++; $display("FAIL reset_seq: got %h want 0", rd); end
    endtask

    task automatic test_all_three();
        bit ok;
        int push_cyc, t0, t1, t2;
        logic [EW-1:0] got, want;
        ev_if.ev_ready = 1'b1;
        set_instr(32'h8000_0000, 32'h0000_0013, 1'b1, 1'b0);
        set_reg(6'd3, 32'h1234_5678, 1'b1);
        set_mem(32'h2000_0040, 32'hCAFE_F00D, 4'h3, 1'b1);
        step();
        push_cyc = cyc;
        wait_obs(3, 20, ok);
        n_checks++;
        if (!ok) begin n_fails++; $display("FAIL all3_count: got %0d events want 3", obs_q.size()); end
        if (ok) begin
            t0 = obs_t[0]; t1 = obs_t[1]; t2 = obs_t[2];
            n_checks++;
            if (t0 != push_cyc + 1 || t1 != t0 + 1 || t2 != t1 + 1) begin
                n_fails++;
                $display("FAIL all3_timing: got cycles %0d,%0d,%0d want %0d,%0d,%0d",
                         t0, t1, t2, push_cyc + 1, push_cyc + 2, push_cyc + 3);
            end
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            got = obs_q.pop_front(); t0 = obs_t.pop_front(); want = exp_q.pop_front();
            n_checks++;
            if (got !== want) begin n_fails++; $display("FAIL all3_event: got %h want %h", got, want); end
        end
        idle(2);
        n_checks++;
        if (ev_if.ev_valid !== 1'b0) begin n_fails++; $display("FAIL all3_idle: got valid %b want 0", ev_if.ev_valid); end
        exp_q.delete(); obs_q.delete(); obs_t.delete();
    endtask

    task automatic test_mem_overflow();
        bit ok;
        int t;
        logic [31:0] rd;
        logic [EW-1:0] got, want;
        ev_if.ev_ready = 1'b0;
        set_instr(32'h8000_0100, 32'h0010_0093, 1'b1, 1'b0);
        step();
        for (int i = 0; i < 6; i++) begin
            set_mem(32'h1000_0000 + 32'(i * 4), $urandom(), 4'($urandom_range(1, 15)), i < DEPTH);
            step();
        end
        cfg_read(CFG_DROP_MEM, rd);
        n_checks++;
        if (rd !== 32'd2) begin n_fails++; $display("FAIL ovf_drop_mem: got %0d want 2", rd); end
        cfg_read(CFG_DROP_INSTR, rd);
        n_checks++;
        if (rd !== 32'd0) begin n_fails++; $display("FAIL ovf_drop_instr: got %0d want 0", rd); end
        cfg_read(CFG_STATUS, rd);
        n_checks++;
        if (rd !== 32'h1C) begin n_fails++; $display("FAIL ovf_status: got %h want %h", rd, 32'h1C); end
        cfg_read(CFG_SEQ, rd);
        n_checks++;
        if (rd !== {16'd0, m_seq}) begin n_fails++; $display("FAIL ovf_seq: got %h want %h", rd, m_seq); end
        cfg_write(CFG_STATUS, 32'h4);
        cfg_write(CFG_DROP_MEM, 32'h0);
        cfg_read(CFG_STATUS, rd);
        n_checks++;
        if (rd !== 32'h18) begin n_fails++; $display("FAIL ovf_status_clr: got %h want %h", rd, 32'h18); end
        cfg_read(CFG_DROP_MEM, rd);
        n_checks++;
        if (rd !== 32'd0) begin n_fails++; $display("FAIL ovf_drop_clr: got %0d want 0", rd); end
        ev_if.ev_ready = 1'b1;
        wait_obs(5, 30, ok);
        n_checks++;
        if (!ok) begin n_fails++; $display("FAIL ovf_count: got %0d events want 5", obs_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            got = obs_q.pop_front(); t = obs_t.pop_front(); want = exp_q.pop_front();
            n_checks++;
            if (got !== want) begin n_fails++; $display("FAIL ovf_event: got %h want %h", got, want); end
        end
        idle(3);
        n_checks++;
        if (ev_if.ev_valid !== 1'b0 || obs_q.size() != 0) begin
            n_fails++;
            $display("FAIL ovf_drain: got valid %b extra %0d, want valid 0 extra 0", ev_if.ev_valid, obs_q.size());
        end
        exp_q.delete(); obs_q.delete(); obs_t.delete();
    endtask

    task automatic test_reg_filter();
        bit ok;
        int t;
        logic [31:0] rd;
        logic [EW-1:0] got, want;
        ev_if.ev_ready = 1'b1;
        set_reg(6'd0, 32'h5555_AAAA, 1'b0);
        step();
        idle(3);
        cfg_read(CFG_SEQ, rd);
        n_checks++;
        if (obs_q.size() != 0 || rd !== {16'd0, m_seq}) begin
            n_fails++;
            $display("FAIL reg_x0: got events %0d seq %h, want 0 events seq %h", obs_q.size(), rd, m_seq);
        end
        set_reg(6'd5, 32'hDEAD_BEEF, 1'b1);
        step();
        wait_obs(1, 10, ok);
        n_checks++;
        if (!ok) begin n_fails++; $display("FAIL reg_count: got %0d events want 1", obs_q.size()); end
        if (ok) begin
            got = obs_q.pop_front(); t = obs_t.pop_front(); want = exp_q.pop_front();
            n_checks++;
            if (got !== want) begin n_fails++; $display("FAIL reg_event: got %h want %h", got, want); end
        end
        exp_q.delete(); obs_q.delete(); obs_t.delete();
    endtask

    task automatic test_enable();
        bit ok;
        int t;
        logic [31:0] rd;
        logic [EW-1:0] got, want;
        ev_if.ev_ready = 1'b1;
        cfg_write(CFG_EN, 32'h0);
        cfg_read(CFG_EN, rd);
        n_checks++;
        if (rd !== 32'h0) begin n_fails++; $display("FAIL en_read: got %h want 0", rd); end
        set_instr(32'h8000_0200, 32'h1, 1'b0, 1'b0);
        set_reg(6'd4, 32'h2, 1'b0);
        set_mem(32'h3000_0000, 32'h3, 4'hF, 1'b0);
        step();
        idle(3);
        cfg_read(CFG_SEQ, rd);
        n_checks++;
        if (obs_q.size() != 0 || rd !== {16'd0, m_seq}) begin
            n_fails++;
            $display("FAIL en_off: got events %0d seq %h, want 0 events seq %h", obs_q.size(), rd, m_seq);
        end
        ev_if.ev_ready = 1'b0;
        cfg_write(CFG_EN, 32'h7);
        set_reg(6'd7, $urandom(), 1'b1);
        step();
        set_reg(6'd9, $urandom(), 1'b1);
        step();
        cfg_write(CFG_EN, 32'h0);
        ev_if.ev_ready = 1'b1;
        wait_obs(2, 10, ok);
        n_checks++;
        if (!ok) begin n_fails++; $display("FAIL en_drain_count: got %0d events want 2", obs_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            got = obs_q.pop_front(); t = obs_t.pop_front(); want = exp_q.pop_front();
            n_checks++;
            if (got !== want) begin n_fails++; $display("FAIL en_drain_event: got %h want %h", got, want); end
        end
        cfg_write(CFG_EN, 32'h7);
        exp_q.delete(); obs_q.delete(); obs_t.delete();
    endtask

    task automatic test_backpressure();
        logic [31:0] rd;
        ev_if.ev_ready = 1'b0;
        set_mem(32'h4000_0010, 32'hA5A5_0001, 4'hC, 1'b1);
        step();
        set_instr(32'h8000_0300, 32'h0000_0033, 1'b1, 1'b0);
        step();
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            n_checks++;
            if ({ev_if.ev_valid, cur_ev()} !== {1'b1, exp_q[0]}) begin
                n_fails++;
                $display("FAIL hold_cycle%0d: got valid=%b ev=%h want valid=1 ev=%h", k, ev_if.ev_valid, cur_ev(), exp_q[0]);
            end
            step();
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_checks++;
        if ({ev_if.ev_valid, cur_ev()} !== '0) begin
            n_fails++;
            $display("FAIL midreset_outputs: got valid=%b ev=%h want all zero", ev_if.ev_valid, cur_ev());
        end
        cfg_read(CFG_SEQ, rd);
        n_checks++;
        if (rd !== 32'h0) begin n_fails++; $display("FAIL midreset_seq: got %h want 0", rd); end
        cfg_read(CFG_STATUS, rd);
        n_checks++;
        if (rd !== 32'h38) begin n_fails++; $display("FAIL midreset_status: got %h want %h", rd, 32'h38); end
        ev_if.ev_ready = 1'b1;
        idle(4);
        n_checks++;
        if (obs_q.size() != 0) begin n_fails++; $display("FAIL midreset_flush: got %0d events want 0", obs_q.size()); end
        exp_q.delete(); obs_q.delete(); obs_t.delete();
        m_seq = '0;
    endtask

    task automatic test_wrap();
        bit ok;
        int t;
        logic [31:0] rd;
        logic [EW-1:0] got, want;
        mon_en = 1'b0;
        ev_if.ev_ready = 1'b1;
        repeat (16'hFFFE) begin
            set_instr(32'h8000_1000, 32'h0000_0013, 1'b0, 1'b0);
            step();
        end
        m_seq = 16'hFFFE;
        idle(4);
        cfg_read(CFG_SEQ, rd);
        n_checks++;
        if (rd !== 32'hFFFE) begin n_fails++; $display("FAIL wrap_preload: got %h want %h", rd, 32'hFFFE); end
        mon_en = 1'b1;
        ev_if.ev_ready = 1'b0;
        set_instr(32'h8000_2000, 32'h0000_1111, 1'b1, 1'b0); step();
        set_reg(6'd10, 32'h0000_2222, 1'b1); step();
        set_instr(32'h8000_2004, 32'h0000_3333, 1'b1, 1'b0); step();
        set_reg(6'd11, 32'h0000_4444, 1'b1); step();
        ev_if.ev_ready = 1'b1;
        wait_obs(4, 20, ok);
        n_checks++;
        if (!ok) begin n_fails++; $display("FAIL wrap_count: got %0d events want 4", obs_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            got = obs_q.pop_front(); t = obs_t.pop_front(); want = exp_q.pop_front();
            n_checks++;
            if (got !== want) begin n_fails++; $display("FAIL wrap_event: got %h want %h", got, want); end
        end
        cfg_read(CFG_SEQ, rd);
        n_checks++;
        if (rd !== 32'h2) begin n_fails++; $display("FAIL wrap_seq: got %h want 2", rd); end
        exp_q.delete(); obs_q.delete(); obs_t.delete();
    endtask

    task automatic test_hwbp();
        bit ok;
        int t;
        logic [31:0] rd;
        logic [EW-1:0] got, want;
        ev_if.ev_ready = 1'b1;
        cfg_write(4'd8, 32'h8000_0011);
        cfg_write(CFG_EN, 32'h6);
`ifdef FWRISC_TRACE_SCHED_HWBP_EN
        cfg_read(4'd8, rd);
        n_checks++;
        if (rd !== 32'h8000_0011) begin n_fails++; $display("FAIL bp_read: got %h want %h", rd, 32'h8000_0011); end
        set_instr(32'h8000_000C, 32'h0000_0513, 1'b0, 1'b0); step();
        set_instr(32'h8000_0010, 32'h0010_0073, 1'b1, 1'b1); step();
        wait_obs(1, 10, ok);
        n_checks++;
        if (!ok) begin n_fails++; $display("FAIL bp_count: got %0d events want 1", obs_q.size()); end
        if (ok) begin
            got = obs_q.pop_front(); t = obs_t.pop_front(); want = exp_q.pop_front();
            n_checks++;
            if (got !== want) begin n_fails++; $display("FAIL bp_event: got %h want %h", got, want); end
        end
`else
        cfg_read(4'd8, rd);
        n_checks++;
        if (rd !== 32'h0) begin n_fails++; $display("FAIL bp_read_off: got %h want 0", rd); end
        set_instr(32'h8000_000C, 32'h0000_0513, 1'b0, 1'b0); step();
        set_instr(32'h8000_0010, 32'h0010_0073, 1'b0, 1'b0); step();
`endif
        idle(3);
        cfg_read(CFG_SEQ, rd);
        n_checks++;
        if (obs_q.size() != 0 || rd !== {16'd0, m_seq}) begin
            n_fails++;
            $display("FAIL bp_tail: got extra %0d seq %h, want extra 0 seq %h", obs_q.size(), rd, m_seq);
        end
        cfg_write(CFG_EN, 32'h7);
        exp_q.delete(); obs_q.delete(); obs_t.delete();
    endtask

    initial begin
        ev_if.ev_ready = 1'b0;
        test_reset();
        test_all_three();
        test_mem_overflow();
        test_reg_filter();
        test_enable();
        test_backpressure();
        test_wrap();
        test_hwbp();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
